// File: rtl/seg7_time_reader.sv
// Scanning readback for the multiplexed 7-segment clock display: walks the digit select,
// decodes each glyph and commits hh:mm:ss + dp. Define SEG7_READER_CONTINUOUS_EN for free-running frames.
module seg7_time_reader #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic [7:0] i_7seg,
    output logic [3:0] o_seg_select,
    output logic [4:0] o_hours,
    output logic [5:0] o_minutes,
    output logic [5:0] o_seconds,
    output logic [5:0] o_dp,
    output logic       o_busy,
    output logic       o_valid,
    output logic       o_error,
    output logic [2:0] o_err_digit
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        CHECK = 2'd2
    } state_t;

    typedef struct packed {
        logic       ok;
        logic [3:0] val;
    } digit_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

    function automatic digit_t decode_glyph(input logic [6:0] g);
        digit_t d;
        d.ok = 1'b1;
        case (g)
            7'h3F:   d.val = 4'd0;
            7'h06:   d.val = 4'd1;
            7'h5B:   d.val = 4'd2;
            7'h4F:   d.val = 4'd3;
            7'h66:   d.val = 4'd4;
            7'h6D:   d.val = 4'd5;
            7'h7D:   d.val = 4'd6;
            7'h07:   d.val = 4'd7;
            7'h7F:   d.val = 4'd8;
            7'h6F:   d.val = 4'd9;
            default: begin
                d.ok  = 1'b0;
                d.val = 4'd0;
            end
        endcase
        return d;
    endfunction

    state_t     state_q, state_d;
    logic [2:0] digit_q, digit_d;
    logic [3:0] settle_q, settle_d;
    logic       capture;
    logic [7:0] glyph_q [6];

    digit_t     dec [6];
    logic [5:0] dp_v;
    logic       bad_any;
    logic [2:0] bad_idx;
    logic       range_bad;
    logic [4:0] hours_v;
    logic [5:0] minutes_v;
    logic [5:0] seconds_v;
    logic       commit;
    logic       reject;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        digit_d  = digit_q;
        settle_d = settle_q;
        capture  = 1'b0;
        case (state_q)
            IDLE: begin
                digit_d  = 3'd0;
                settle_d = 4'd0;
`ifdef SEG7_READER_CONTINUOUS_EN
                state_d  = SCAN;
`else
                if (i_start) state_d = SCAN;
`endif
            end
            SCAN: begin
                if (settle_q == SETTLE_LAST) begin
                    capture  = 1'b1;
                    settle_d = 4'd0;
                    if (digit_q == 3'd5) state_d = CHECK;
                    else                 digit_d = digit_q + 3'd1;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            CHECK: begin
                digit_d  = 3'd0;
                settle_d = 4'd0;
`ifdef SEG7_READER_CONTINUOUS_EN
                state_d  = SCAN;
`else
                state_d  = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    for (genvar i = 0; i < 6; i++) begin : g_decode
        assign dec[i]  = decode_glyph(glyph_q[i][6:0]);
        assign dp_v[i] = glyph_q[i][7];
    end

    // Descending scan leaves the lowest bad index in bad_idx.
    always_comb begin
        bad_any = 1'b0;
        bad_idx = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (!dec[i].ok) begin
                bad_any = 1'b1;
                bad_idx = 3'(i);
            end
        end
    end

    assign hours_v   = (5'(dec[0].val) << 3) + (5'(dec[0].val) << 1) + 5'(dec[1].val);
    assign minutes_v = (6'(dec[2].val) << 3) + (6'(dec[2].val) << 1) + 6'(dec[3].val);
    assign seconds_v = (6'(dec[4].val) << 3) + (6'(dec[4].val) << 1) + 6'(dec[5].val);
    assign range_bad = (dec[0].val > 4'd2) || (hours_v > 5'd23) ||
                       (dec[2].val > 4'd5) || (dec[4].val > 4'd5);

    assign commit = (state_q == CHECK) && !bad_any && !range_bad;
    assign reject = (state_q == CHECK) && (bad_any || range_bad);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            digit_q     <= 3'd0;
            settle_q    <= 4'd0;
            o_hours     <= 5'd0;
            o_minutes   <= 6'd0;
            o_seconds   <= 6'd0;
            o_dp        <= 6'd0;
            o_valid     <= 1'b0;
            o_error     <= 1'b0;
            o_err_digit <= 3'd0;
        end else begin
            state_q  <= state_d;
            digit_q  <= digit_d;
            settle_q <= settle_d;
            o_valid  <= commit;
            o_error  <= reject;
            if (commit) begin
                o_hours   <= hours_v;
                o_minutes <= minutes_v;
                o_seconds <= seconds_v;
                o_dp      <= dp_v;
            end
            if (reject) o_err_digit <= bad_any ? bad_idx : 3'd6;
        end
    end

    // NOTE: glyph storage is left unreset; every slot is rewritten before CHECK reads it.
    always_ff @(posedge clk) begin
        if (capture) glyph_q[digit_q] <= i_7seg;
    end

    assign o_seg_select = {1'b0, digit_q};
    assign o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_seg7_time_reader.sv
// Self-checking bench for seg7_time_reader: a behavioural encoder drives the segment bus from
// o_seg_select; table vectors, randomized frames and multi-cycle corner sequences follow.
module tb_seg7_time_reader;

`ifdef SEG7_READER_CONTINUOUS_EN
    localparam int S = 0;
`else
    localparam int S = 1;
`endif
    localparam int LAT = 6 * (S + 1) + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic [7:0] i_7seg;
    logic [3:0] o_seg_select;
    logic [4:0] o_hours;
    logic [5:0] o_minutes;
    logic [5:0] o_seconds;
    logic [5:0] o_dp;
    logic       o_busy;
    logic       o_valid;
    logic       o_error;
    logic [2:0] o_err_digit;

    int checks   = 0;
    int failures = 0;

    seg7_time_reader #(.SETTLE_CYCLES(S)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start      (i_start),
        .i_7seg       (i_7seg),
        .o_seg_select (o_seg_select),
        .o_hours      (o_hours),
        .o_minutes    (o_minutes),
        .o_seconds    (o_seconds),
        .o_dp         (o_dp),
        .o_busy       (o_busy),
        .o_valid      (o_valid),
        .o_error      (o_error),
        .o_err_digit  (o_err_digit)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    logic [7:0] frame_g [6];
    int         corrupt_idx = -1;
    logic [7:0] corrupt_val = 8'h00;

    // Encoder stand-in: the bus follows the select combinationally.
    always_comb begin
        i_7seg = 8'h00;
        if (o_seg_select < 4'd6) begin
            i_7seg = frame_g[o_seg_select[2:0]];
            if (corrupt_idx == int'(o_seg_select)) i_7seg = corrupt_val;
        end
    end

    // Reference state: last committed frame and last error cause.
    int         m_h = 0, m_m = 0, m_s = 0, m_err = 0;
    logic [5:0] m_dp = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic encode(input int h, input int m, input int s, input logic [5:0] dp);
        int d [6];
        d = '{h / 10, h % 10, m / 10, m % 10, s / 10, s % 10};
        for (int k = 0; k < 6; k++) frame_g[k] = {dp[k], seg_tab[d[k]]};
    endtask

    function automatic int glyph_value(input logic [6:0] g);
        for (int i = 0; i < 10; i++) if (seg_tab[i] == g) return i;
        return -1;
    endfunction

    task automatic model_frame(output logic ev, output logic ee);
        logic [7:0] eff [6];
        int         d [6];
        int         bad;
        bad = -1;
        ev  = 1'b0;
        ee  = 1'b0;
        for (int k = 0; k < 6; k++) begin
            eff[k] = (corrupt_idx == k) ? corrupt_val : frame_g[k];
            d[k]   = glyph_value(eff[k][6:0]);
            if (bad < 0 && d[k] < 0) bad = k;
        end
        if (bad >= 0) begin
            ee = 1'b1;
            m_err = bad;
        end else if (d[0] * 10 + d[1] > 23 || d[2] > 5 || d[4] > 5) begin
            ee = 1'b1;
            m_err = 6;
        end else begin
            ev  = 1'b1;
            m_h = d[0] * 10 + d[1];
            m_m = d[2] * 10 + d[3];
            m_s = d[4] * 10 + d[5];
            for (int k = 0; k < 6; k++) m_dp[k] = eff[k][7];
        end
    endtask

    // Starts one frame and returns the edge count (after the start edge) of the first pulse.
    task automatic do_frame(output int n);
        n = -1;
        @(negedge clk) i_start = 1'b1;
        @(negedge clk) i_start = 1'b0;
        for (int i = 1; i <= LAT + 10; i++) begin
            @(posedge clk);
            #1;
            if (o_valid || o_error) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic check_frame(input string tag, input int n, input logic ev, input logic ee,
                               input int eh, input int em, input int es, input logic [5:0] edp,
                               input int ed);
        check({tag, ".latency"}, 64'(n), 64'(LAT));
        check({tag, ".valid"}, 64'(o_valid), 64'(ev));
        check({tag, ".error"}, 64'(o_error), 64'(ee));
        check({tag, ".hours"}, 64'(o_hours), 64'(eh));
        check({tag, ".minutes"}, 64'(o_minutes), 64'(em));
        check({tag, ".seconds"}, 64'(o_seconds), 64'(es));
        check({tag, ".dp"}, 64'(o_dp), 64'(edp));
        check({tag, ".err_digit"}, 64'(o_err_digit), 64'(ed));
        check({tag, ".busy"}, 64'(o_busy), 64'(0));
        @(posedge clk);
        #1;
        check({tag, ".pulse_len"}, 64'({o_valid, o_error}), 64'(0));
    endtask

    typedef struct {
        string      name;
        int         h, m, s;
        logic [5:0] dp;
        int         cidx;
        logic [7:0] cval;
        logic       ev, ee;
        int         eh, em, es;
        logic [5:0] edp;
        int         ed;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int         n, pulses, first, busy_hi;
        logic       ev, ee;
        for (int k = 0; k < 6; k++) frame_g[k] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset.outputs", 64'({o_seg_select, o_hours, o_minutes, o_seconds, o_dp,
                                    o_busy, o_valid, o_error, o_err_digit}), 64'(0));

`ifdef SEG7_READER_CONTINUOUS_EN
        encode(23, 59, 59, 6'b000000);
        @(negedge clk) rst_n = 1'b1;
        first  = -1;
        pulses = 0;
        for (int i = 1; i <= 10 * LAT; i++) begin
            @(posedge clk);
            #1;
            if (o_error) check("cont.error", 64'(o_error), 64'(0));
            if (o_valid) begin
                if (first >= 0) check("cont.period", 64'(i - first), 64'(LAT));
                check("cont.time", 64'({o_hours, o_minutes, o_seconds}),
                      64'({5'd23, 6'd59, 6'd59}));
                first = i;
                pulses++;
            end
            i_start = 1'($urandom_range(0, 1));
        end
        check("cont.pulses", 64'(pulses), 64'(9));
        check("cont.busy", 64'(o_busy), 64'(1));
`else
        @(negedge clk) rst_n = 1'b1;

        vecs[0] = '{"v_12_30_59", 12, 30, 59, 6'b000100, -1, 8'h00, 1, 0, 12, 30, 59, 6'b000100, 0};
        vecs[1] = '{"v_blank_d3", 12, 30, 59, 6'b000100,  3, 8'h00, 0, 1, 12, 30, 59, 6'b000100, 3};
        vecs[2] = '{"v_24_00_00", 24,  0,  0, 6'b000000, -1, 8'h00, 0, 1, 12, 30, 59, 6'b000100, 6};
        vecs[3] = '{"v_12_60_00", 12, 60,  0, 6'b000000, -1, 8'h00, 0, 1, 12, 30, 59, 6'b000100, 6};
        vecs[4] = '{"v_23_59_59", 23, 59, 59, 6'b111111, -1, 8'h00, 1, 0, 23, 59, 59, 6'b111111, 6};
        vecs[5] = '{"v_00_00_00",  0,  0,  0, 6'b000000, -1, 8'h00, 1, 0,  0,  0,  0, 6'b000000, 6};
        vecs[6] = '{"v_dp_only0",  9,  8,  7, 6'b000000,  0, 8'h80, 0, 1,  0,  0,  0, 6'b000000, 0};
        vecs[7] = '{"v_dp_on_d5", 19, 45, 30, 6'b000000,  5, 8'hBF, 1, 0, 19, 45, 30, 6'b100000, 0};

        foreach (vecs[i]) begin
            encode(vecs[i].h, vecs[i].m, vecs[i].s, vecs[i].dp);
            corrupt_idx = vecs[i].cidx;
            corrupt_val = vecs[i].cval;
            do_frame(n);
            check_frame(vecs[i].name, n, vecs[i].ev, vecs[i].ee, vecs[i].eh, vecs[i].em,
                        vecs[i].es, vecs[i].edp, vecs[i].ed);
            m_h = vecs[i].eh; m_m = vecs[i].em; m_s = vecs[i].es;
            m_dp = vecs[i].edp; m_err = vecs[i].ed;
        end
        corrupt_idx = -1;

        // A second start inside the frame must be ignored, not queued.
        encode(7, 5, 3, 6'b010010);
        model_frame(ev, ee);
        @(negedge clk) i_start = 1'b1;
        @(negedge clk) i_start = 1'b0;
        pulses = 0;
        first  = -1;
        for (int i = 1; i <= 3 * LAT; i++) begin
            @(posedge clk);
            #1;
            if (o_valid) begin
                pulses++;
                if (first < 0) first = i;
            end
            if (i == 3) i_start = 1'b1;
            if (i == 4) i_start = 1'b0;
        end
        check("restart.pulses", 64'(pulses), 64'(1));
        check("restart.edge", 64'(first), 64'(LAT));
        check("restart.time", 64'({o_hours, o_minutes, o_seconds, o_dp}),
              64'({5'(m_h), 6'(m_m), 6'(m_s), m_dp}));

        for (int r = 0; r < 30; r++) begin
            if ($urandom_range(0, 3) == 0)
                encode($urandom_range(0, 29), $urandom_range(0, 69), $urandom_range(0, 69),
                       6'($urandom));
            else
                encode($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59),
                       6'($urandom));
            corrupt_idx = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 5)) : -1;
            corrupt_val = 8'($urandom);
            model_frame(ev, ee);
            do_frame(n);
            check_frame($sformatf("rand%0d", r), n, ev, ee, m_h, m_m, m_s, m_dp, m_err);
        end
        corrupt_idx = -1;

        // Reset landing at cycle 7 of a frame discards it.
        encode(11, 22, 33, 6'b000001);
        @(negedge clk) i_start = 1'b1;
        @(negedge clk) i_start = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midreset.outputs", 64'({o_seg_select, o_hours, o_minutes, o_seconds, o_dp,
                                      o_busy, o_valid, o_error, o_err_digit}), 64'(0));
        pulses  = 0;
        busy_hi = 0;
        for (int i = 1; i <= 2 * LAT; i++) begin
            @(posedge clk);
            #1;
            if (o_valid || o_error) pulses++;
            if (o_busy) busy_hi++;
        end
        check("midreset.pulses", 64'(pulses), 64'(0));
        check("midreset.idle", 64'(busy_hi), 64'(0));
        m_h = 0; m_m = 0; m_s = 0; m_dp = '0; m_err = 0;

        model_frame(ev, ee);
        do_frame(n);
        check_frame("recover", n, ev, ee, m_h, m_m, m_s, m_dp, m_err);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_time_reader.md
# seg7_time_reader

Scanning reader for the multiplexed 7-segment clock display: steps the digit select through all six digits, samples the segment bus for each, decodes glyphs back to BCD, and rebuilds binary hours/minutes/seconds plus decimal points. It is the inverse of the clock-to-7-segment encoder. It sits on that encoder's `i_seg_select`/`o_7seg` pair, where it serves as a self-check and readback path and as a bench monitor.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 1: extra cycles the select is held before sampling; legal range 0..15.

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  reset; one clock; reset is synchronous and active-low
- `i_start`  in  1  begin one frame scan; sampled only in IDLE
- `i_7seg`  in  8  segment bus; [0]=a … [6]=g, [7]=dp; active high
- `o_seg_select`  out  4  digit being read; 0 = hours MSD … 5 = seconds LSD
- `o_hours`  out  5  last good hours, 0..23
- `o_minutes`  out  6  last good minutes, 0..59
- `o_seconds`  out  6  last good seconds, 0..59
- `o_dp`  out  6  last good dp bits; `o_dp[k]` = dp of digit k
- `o_busy`  out  1  scan in progress
- `o_valid`  out  1  one-cycle pulse: good frame committed
- `o_error`  out  1  one-cycle pulse: bad frame rejected
- `o_err_digit`  out  3  cause of last error; 0..5 = first bad glyph index, 6 = range error

## Operation
- FSM states:
  - IDLE: `o_busy`=0, `o_seg_select`=0. `i_start`=1 moves to SCAN with digit k=0.
  - SCAN: drive `o_seg_select`=k for SETTLE_CYCLES+1 cycles, then capture `i_7seg` into the digit-k slot. If k<5, advance k. If k=5, go to CHECK.
  - CHECK: one cycle. Validate, then commit or reject. Return to IDLE.
- Glyph decode accepts only these exact 7-bit patterns:
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66
  - 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F
  - Any other pattern, including blank 0x00, is an invalid glyph.
- Range rules, checked only when all glyphs are valid:
  - hours tens ≤2, and hours = tens·10+ones ≤23
  - minutes tens ≤5
  - seconds tens ≤5
- Arithmetic: value = tens·10 + ones, computed as (tens<<3)+(tens<<1)+ones, truncated to the output width.
- Commit (good frame): load `o_hours`, `o_minutes`, `o_seconds`, `o_dp`; pulse `o_valid`.
- Reject: the value outputs and `o_dp` hold their previous contents.
  - `o_err_digit` = lowest invalid glyph index, else 6 for a range error.
  - Pulse `o_error`.
- `o_valid` and `o_error` are never high together.
- `i_start` while `o_busy`=1 is ignored; there is no queued restart.
- Changes on `i_7seg` outside the sampling edge have no effect.

## Timing
- Reset, `rst_n`=0 at a rising edge, forces:
  - state IDLE, k=0
  - all outputs 0: `o_seg_select`, the value registers, `o_dp`, `o_busy`, `o_valid`, `o_error`, `o_err_digit`
- A frame in progress when reset hits is discarded, with no `o_valid` or `o_error`.
- Let `i_start` be sampled high at edge E, and S = SETTLE_CYCLES:
  - `o_seg_select`=k and `o_busy`=1 are visible from E+k·(S+1).
  - Digit k is sampled at edge E+(k+1)·(S+1).
  - Results and the pulse are visible after edge E+6(S+1)+1, high for exactly one cycle. `o_busy` drops in the same cycle.
  - With S=1, the result appears 13 edges after start.
- Earliest next start: the edge that ends the pulse cycle.
- S=0 is legal. The encoder path must then be combinational within one cycle.

## Configuration
- `SEG7_READER_CONTINUOUS_EN` defined:
  - Ignore `i_start`.
  - Frames run back-to-back from reset release; CHECK goes straight to SCAN with k=0.
  - Frame period is 6(S+1)+1 cycles, and `o_busy` stays 1.
- Undefined: single-shot operation on `i_start`, as described above.

## Test plan
- Loopback with the encoder, S=1, input 12:30:59, dp=6'b000100, `i_start` pulse → 13 edges later `o_valid`=1 for 1 cycle; `o_hours`=12, `o_minutes`=30, `o_seconds`=59, `o_dp`=6'b000100.
- Force `i_7seg`=0x00 while digit 3 is selected → `o_error` pulse, `o_err_digit`=3, outputs still hold the previous frame's values.
- Encoder fed 24:00:00, and separately 12:60:00 → `o_error`, `o_err_digit`=6, no `o_valid`.
- Second `i_start` at cycle 4 of a frame → exactly one `o_valid`, still at edge 13.
- `rst_n` low for one edge at cycle 7 of a frame → all outputs 0, no pulse afterwards, IDLE until the next `i_start`.
- `SEG7_READER_CONTINUOUS_EN`, S=0, value 23:59:59 → `o_valid` every 7 cycles, values constant, `i_start` ignored.
